// File: rtl/vote_pkg.sv
// Shared voting-path definitions: voter count, collector states, decision codes.
package vote_pkg;

    localparam int N_VOTERS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } collect_state_t;

    // One-hot decision codes consumed by the downstream decision stage.
    localparam logic [2:0] DEC_TAIL = 3'b100;  // 0-1 yes
    localparam logic [2:0] DEC_TIE  = 3'b010;  // 2 yes
    localparam logic [2:0] DEC_WIN  = 3'b001;  // 3-4 yes

    function automatic logic [2:0] decide(input logic [N_VOTERS-1:0] ballot);
        int yes;
        yes = 0;
        for (int i = 0; i < N_VOTERS; i++) begin
            yes += int'(ballot[i]);
        end
        if (yes >= 3) begin
            return DEC_WIN;
        end else if (yes == 2) begin
            return DEC_TIE;
        end
        return DEC_TAIL;
    endfunction

endpackage

// File: rtl/window_timer.sv
// Voting-window counter: clear loads 0, run increments, expire flags the last window cycle.
// Latency: expire is decoded from the registered count, valid in the same cycle as the count.
// Backpressure: none; the collector decides when to run or reload.
module window_timer
    import vote_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1000,
    parameter int CNT_W         = $clog2(WINDOW_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = run && (cnt == LAST);

endmodule

// File: rtl/ballot_collector.sv
// Collects at most one vote per voter inside a timed window, then offers the ballot downstream.
// Latency: ballot_valid rises the cycle after the fourth distinct vote or the last window cycle.
// Backpressure: ballot, timeout and voted hold in PRESENT until ballot_ready; new votes are ignored.
module ballot_collector
    import vote_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1000,
    parameter int CNT_W         = $clog2(WINDOW_CYCLES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_en,
    input  logic [N_VOTERS-1:0] vote_val,
    input  logic                ballot_ready,
    output logic [N_VOTERS-1:0] ballot,
    output logic                ballot_valid,
    output logic                timeout,
    output logic [N_VOTERS-1:0] voted,
    output logic                busy
);

    localparam logic [N_VOTERS-1:0] ALL_VOTED = {N_VOTERS{1'b1}};

    collect_state_t      state;
    logic                timer_clear;
    logic                timer_run;
    logic                expire;
    logic [N_VOTERS-1:0] new_vote;
    logic [N_VOTERS-1:0] nxt_voted;
    logic [N_VOTERS-1:0] nxt_ballot;

    assign timer_clear = (state == IDLE) && start;
    assign timer_run   = (state == COLLECT);

    window_timer #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .CNT_W         (CNT_W)
    ) u_window_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .run    (timer_run),
        .expire (expire)
    );

    // Only first-time voters update the ballot; repeat strobes leave earlier votes intact.
    assign new_vote   = vote_en & ~voted;
    assign nxt_voted  = voted | new_vote;
    assign nxt_ballot = (ballot & ~new_vote) | (vote_val & new_vote);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ballot       <= '0;
            voted        <= '0;
            timeout      <= 1'b0;
            ballot_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= COLLECT;
                        ballot  <= '0;
                        voted   <= '0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                COLLECT: begin
                    ballot <= nxt_ballot;
                    voted  <= nxt_voted;
                    if (nxt_voted == ALL_VOTED) begin
                        state        <= PRESENT;
                        timeout      <= 1'b0;
                        ballot_valid <= 1'b1;
                    end else if (expire) begin
                        state        <= PRESENT;
                        timeout      <= 1'b1;
                        ballot_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (ballot_ready) begin
                        state        <= IDLE;
                        ballot_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    ballot_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
